// File: rtl/boot_rom_pipe.sv
// rtl/boot_rom_pipe.sv - boot ROM that serves a jump stub to the strapped boot address over a req/gnt/rvalid port
module boot_rom_pipe #(
    parameter int          Depth       = 8,
    parameter int          AddrWidth   = 32,
    parameter int          Latency     = 1,
    parameter logic [31:0] DefaultBoot = 32'h1A00_0080
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 boot_sel_i,
    input  logic [31:0]          boot_addr_i,
    input  logic                 req_i,
    input  logic [AddrWidth-1:0] addr_i,
    output logic                 gnt_o,
    output logic                 rvalid_o,
    output logic [31:0]          rdata_o,
    output logic                 err_o
);

    localparam int IdxW = $clog2(Depth);
    localparam logic [AddrWidth-3:0] DepthA = (AddrWidth-2)'(Depth);

    initial begin
        assert (Latency >= 1 && Latency <= 4)
            else $fatal(1, "boot_rom_pipe: Latency must be within 1..4");
        assert (Depth >= 4)
            else $fatal(1, "boot_rom_pipe: Depth must be at least 4");
    end

    logic [31:0]     tgt_q, tgt_d;
    logic [19:0]     hi;
    logic [11:0]     lo;
    logic [31:0]     word;

    logic [Latency-1:0] vld_q;
    logic [Latency-1:0] err_q;
    logic [IdxW-1:0]    idx_q [Latency];

    logic            req_err;
    logic [IdxW-1:0] req_idx;
    logic            out_vld;
    logic            out_err;
    logic [IdxW-1:0] out_idx;

    // Strap is sampled on every reset cycle and then frozen until the next reset.
    always_comb begin
        tgt_d = tgt_q;
        if (rst_i) begin
            tgt_d = boot_sel_i ? boot_addr_i : DefaultBoot;
        end
    end

    always_ff @(posedge clk_i) begin
        tgt_q <= tgt_d;
    end

    assign gnt_o   = req_i & ~rst_i;
    assign req_err = (addr_i[1:0] != 2'b00) | (addr_i[AddrWidth-1:2] >= DepthA);
    assign req_idx = addr_i[IdxW+1:2];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            vld_q <= '0;
            err_q <= '0;
            for (int i = 0; i < Latency; i++) begin
                idx_q[i] <= '0;
            end
        end else begin
            vld_q[0] <= gnt_o;
            err_q[0] <= req_err;
            idx_q[0] <= req_idx;
            for (int i = 1; i < Latency; i++) begin
                vld_q[i] <= vld_q[i-1];
                err_q[i] <= err_q[i-1];
                idx_q[i] <= idx_q[i-1];
            end
        end
    end

    // lui loads hi while jalr sign-extends lo, so hi is pre-incremented when lo[11] is set.
    always_comb begin
        hi = tgt_q[31:12] + 20'(tgt_q[11]);
        lo = tgt_q[11:0];
    end

    assign out_vld = vld_q[Latency-1];
    assign out_err = err_q[Latency-1];
    assign out_idx = idx_q[Latency-1];

    always_comb begin
        word = 32'h0000_0000;
        case (out_idx)
            IdxW'(0): word = 32'h0000_0013;
            IdxW'(1): word = {hi, 5'd1, 7'b0110111};
            IdxW'(2): word = {lo, 5'd1, 3'b000, 5'd0, 7'b1100111};
            IdxW'(3): word = 32'h0000_006F;
            default:  word = 32'h0000_0000;
        endcase
    end

    // A response still in the pipe when reset arrives is dropped, not delivered.
    always_comb begin
        rvalid_o = out_vld & ~rst_i;
        err_o    = rvalid_o & out_err;
        rdata_o  = (rvalid_o & ~out_err) ? word : 32'h0000_0000;
    end

endmodule

// File: tb/tb_boot_rom_pipe.sv
// tb/tb_boot_rom_pipe.sv - scoreboard bench for boot_rom_pipe at Latency 1 and 3
module tb_boot_rom_pipe;

    typedef struct packed {
        int unsigned cyc;
        logic [31:0] data;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        boot_sel = 1'b0;
    logic [31:0] boot_addr = 32'h0;
    logic        req = 1'b0;
    logic [31:0] addr = 32'h0;

    logic        gnt1, rvalid1, err1;
    logic [31:0] rdata1;
    logic        gnt3, rvalid3, err3;
    logic [31:0] rdata3;

    int unsigned cyc = 0;
    int          checks = 0;
    int          failures = 0;
    logic        mon_en = 1'b0;
    logic [31:0] model_tgt = 32'h1A00_0080;
    exp_t        q1 [$];
    exp_t        q3 [$];

    boot_rom_pipe #(.Depth(8), .AddrWidth(32), .Latency(1), .DefaultBoot(32'h1A00_0080)) u_dut1 (
        .clk_i(clk), .rst_i(rst), .boot_sel_i(boot_sel), .boot_addr_i(boot_addr),
        .req_i(req), .addr_i(addr), .gnt_o(gnt1), .rvalid_o(rvalid1),
        .rdata_o(rdata1), .err_o(err1)
    );

    boot_rom_pipe #(.Depth(8), .AddrWidth(32), .Latency(3), .DefaultBoot(32'h1A00_0080)) u_dut3 (
        .clk_i(clk), .rst_i(rst), .boot_sel_i(boot_sel), .boot_addr_i(boot_addr),
        .req_i(req), .addr_i(addr), .gnt_o(gnt3), .rvalid_o(rvalid3),
        .rdata_o(rdata3), .err_o(err3)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] model_word(input logic [31:0] t, input logic [31:0] a);
        logic [19:0] h;
        logic [31:0] i;
        h = t[31:12] + {19'b0, t[11]};
        i = a >> 2;
        if (a[1:0] != 2'b00 || i >= 8) return 32'h0;
        case (i)
            0: return 32'h0000_0013;
            1: return {h, 12'h0} | 32'h0000_00B7;
            2: return {t[11:0], 20'h0} | 32'h0000_8067;
            3: return 32'h0000_006F;
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic model_err(input logic [31:0] a);
        return (a[1:0] != 2'b00) || ((a >> 2) >= 8);
    endfunction

    always @(negedge clk) begin
        if (mon_en) begin
            while (q1.size() > 0 && q1[0].cyc < cyc) begin
                checks++; failures++;
                $display("FAIL l1_missing_rvalid cyc=%0d expected_at=%0d", cyc, q1[0].cyc);
                void'(q1.pop_front());
            end
            if (rvalid1) begin
                checks++;
                if (q1.size() == 0 || q1[0].cyc != cyc) begin
                    failures++;
                    $display("FAIL l1_unexpected_rvalid cyc=%0d rdata=%h", cyc, rdata1);
                end else begin
                    exp_t e;
                    e = q1.pop_front();
                    checks++;
                    if (rdata1 !== e.data || err1 !== e.err) begin
                        failures++;
                        $display("FAIL l1_resp cyc=%0d got rdata=%h err=%b want rdata=%h err=%b",
                                 cyc, rdata1, err1, e.data, e.err);
                    end
                end
            end else begin
                checks++;
                if (rdata1 !== 32'h0 || err1 !== 1'b0) begin
                    failures++;
                    $display("FAIL l1_idle cyc=%0d got rdata=%h err=%b want 0/0", cyc, rdata1, err1);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (mon_en) begin
            while (q3.size() > 0 && q3[0].cyc < cyc) begin
                checks++; failures++;
                $display("FAIL l3_missing_rvalid cyc=%0d expected_at=%0d", cyc, q3[0].cyc);
                void'(q3.pop_front());
            end
            if (rvalid3) begin
                checks++;
                if (q3.size() == 0 || q3[0].cyc != cyc) begin
                    failures++;
                    $display("FAIL l3_unexpected_rvalid cyc=%0d rdata=%h", cyc, rdata3);
                end else begin
                    exp_t e;
                    e = q3.pop_front();
                    checks++;
                    if (rdata3 !== e.data || err3 !== e.err) begin
                        failures++;
                        $display("FAIL l3_resp cyc=%0d got rdata=%h err=%b want rdata=%h err=%b",
                                 cyc, rdata3, err3, e.data, e.err);
                    end
                end
            end else begin
                checks++;
                if (rdata3 !== 32'h0 || err3 !== 1'b0) begin
                    failures++;
                    $display("FAIL l3_idle cyc=%0d got rdata=%h err=%b want 0/0", cyc, rdata3, err3);
                end
            end
        end
    end

    // Drives one request for one cycle; caller is positioned just after a rising edge.
    task automatic issue(input logic [31:0] a, input logic [31:0] exp_data, input logic exp_err);
        req  = 1'b1;
        addr = a;
        q1.push_back('{cyc + 1, exp_data, exp_err});
        q3.push_back('{cyc + 3, exp_data, exp_err});
        @(negedge clk);
        checks++;
        if (gnt1 !== 1'b1 || gnt3 !== 1'b1) begin
            failures++;
            $display("FAIL gnt addr=%h got gnt1=%b gnt3=%b want 1", a, gnt1, gnt3);
        end
        @(posedge clk); #1;
        req = 1'b0;
    endtask

    task automatic issue_model(input logic [31:0] a);
        issue(a, model_word(model_tgt, a), model_err(a));
    endtask

    task automatic do_reset(input logic sel, input logic [31:0] baddr, input int n);
        rst       = 1'b1;
        req       = 1'b1;
        addr      = 32'h4;
        boot_sel  = sel;
        boot_addr = baddr;
        model_tgt = sel ? baddr : 32'h1A00_0080;
        q1.delete();
        q3.delete();
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            checks++;
            if (gnt1 !== 1'b0 || gnt3 !== 1'b0 || rvalid1 !== 1'b0 || rvalid3 !== 1'b0) begin
                failures++;
                $display("FAIL reset_outputs got gnt=%b%b rvalid=%b%b want 0", gnt1, gnt3, rvalid1, rvalid3);
            end
            @(posedge clk); #1;
        end
        rst = 1'b0;
        req = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((q1.size() > 0 || q3.size() > 0) && n < 12) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (q1.size() > 0 || q3.size() > 0) begin
            failures++;
            $display("FAIL drain_timeout pending l1=%0d l3=%0d want 0", q1.size(), q3.size());
            q1.delete();
            q3.delete();
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        @(posedge clk); #1;
        mon_en = 1'b1;
        do_reset(1'b0, 32'hDEAD_BEEF, 2);
        @(negedge clk);
        checks++;
        if (rvalid1 !== 1'b0 || rvalid3 !== 1'b0 || rdata1 !== 32'h0 || rdata3 !== 32'h0) begin
            failures++;
            $display("FAIL post_reset got rvalid=%b%b rdata=%h/%h want 0", rvalid1, rvalid3, rdata1, rdata3);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_default_boot();
        issue(32'h0, 32'h0000_0013, 1'b0);
        issue(32'h4, 32'h1A00_00B7, 1'b0);
        issue(32'h8, 32'h0800_8067, 1'b0);
        wait_drain();
    endtask

    task automatic test_errors();
        issue(32'h2,  32'h0, 1'b1);
        issue(32'h20, 32'h0, 1'b1);
        issue(32'hC,  32'h0000_006F, 1'b0);
        issue(32'h1C, 32'h0, 1'b0);
        issue(32'h8000_0004, 32'h0, 1'b1);
        issue(32'h5, 32'h0, 1'b1);
        wait_drain();
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 5; i++) begin
            issue_model(32'(i * 4));
        end
        wait_drain();
    endtask

    task automatic test_sign_ext();
        do_reset(1'b1, 32'h1C00_8800, 2);
        issue(32'h4, 32'h1C00_90B7, 1'b0);
        issue(32'h8, 32'h8000_8067, 1'b0);
        wait_drain();
        do_reset(1'b1, 32'hFFFF_F800, 1);
        issue(32'h4, 32'h0000_00B7, 1'b0);
        issue(32'h8, 32'h8000_8067, 1'b0);
        wait_drain();
    endtask

    task automatic test_reset_midflight();
        issue_model(32'h4);
        issue_model(32'h8);
        do_reset(1'b1, 32'h1234_5FFC, 2);
        boot_addr = 32'hFFFF_F000;
        boot_sel  = 1'b0;
        issue(32'h4, 32'h1234_60B7, 1'b0);
        issue(32'h8, 32'hFFC0_8067, 1'b0);
        wait_drain();
    endtask

    task automatic test_random();
        logic [31:0] a;
        for (int i = 0; i < 10; i++) begin
            a = 32'($urandom_range(0, 47));
            issue_model(a);
        end
        wait_drain();
    endtask

    initial begin
        test_reset();
        test_default_boot();
        test_errors();
        test_back_to_back();
        test_sign_ext();
        test_reset_midflight();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
